// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and constants for the PLL reset generator.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int ARESET_LEN = 8;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop single-bit synchronizer, async active-low reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= '0;
        else        ff_q <= {ff_q[STAGES-2:0], d_i};
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pll_rst_gen.sv
// pll_rst_gen: qualifies PLL lock, sequences system reset, counts lock losses.
// Optional PLL restart-on-timeout logic is built when PLL_RESTART_EN is defined.
module pll_rst_gen
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int RST_HOLD_CYC    = 16,
    parameter int CNT_W           = 16,
    parameter int RESTART_CYC     = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_rst_req,
    output logic             rst_out_n,
    output logic             sys_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]       state_o,
    output logic             pll_areset
);

    localparam int CW = $clog2(imax(LOCK_STABLE_CYC, RST_HOLD_CYC)) + 1;

    if (SYNC_STAGES < 2 || RESTART_CYC < ARESET_LEN) begin : g_bad_param
        $error("pll_rst_gen: illegal parameter set");
    end

    logic          locked_s;
    logic          lose;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q;
    logic          run_q;
    logic          lost_q;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (pll_locked),
        .q_o  (locked_s)
    );

    assign lose = (state_q == RUN) && !locked_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: state_d = locked_s ? STABLE : WAIT_LOCK;
            STABLE: begin
                if (!locked_s)                                 state_d = WAIT_LOCK;
                else if (cnt_q == CW'(LOCK_STABLE_CYC - 1))    state_d = HOLD;
                else                                           cnt_d   = cnt_q + CW'(1);
            end
            HOLD: begin
                if (!locked_s)                                 state_d = WAIT_LOCK;
                else if (cnt_q == CW'(RST_HOLD_CYC - 1))       state_d = RUN;
                else                                           cnt_d   = cnt_q + CW'(1);
            end
            RUN: begin
                if (!locked_s)       state_d = WAIT_LOCK;
                else if (sw_rst_req) state_d = HOLD;
            end
        endcase
    end

    // Outputs follow the next state so they switch on the same edge as state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            lost_q  <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= (state_d == RUN);
            lost_q  <= lose;
            loss_q  <= loss_q + CNT_W'(lose && (loss_q != '1));
        end
    end

    assign rst_out_n     = run_q;
    assign sys_ready     = run_q;
    assign lock_lost     = lost_q;
    assign lock_loss_cnt = loss_q;
    assign state_o       = state_q;

`ifdef PLL_RESTART_EN
    localparam int TW = $clog2(RESTART_CYC) + 1;
    localparam int AW = $clog2(ARESET_LEN);

    logic [TW-1:0] to_q;
    logic [AW-1:0] ar_q;
    logic          areset_q;
    logic          tmo;

    assign tmo = (state_q == WAIT_LOCK) && (to_q == TW'(RESTART_CYC - 1));

    // A started pulse runs to completion independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q     <= '0;
            ar_q     <= '0;
            areset_q <= 1'b0;
        end else begin
            to_q <= (state_q != WAIT_LOCK || tmo) ? '0 : to_q + TW'(1);
            if (tmo) begin
                areset_q <= 1'b1;
                ar_q     <= AW'(ARESET_LEN - 1);
            end else if (ar_q == '0) begin
                areset_q <= 1'b0;
            end else begin
                ar_q <= ar_q - AW'(1);
            end
        end
    end

    assign pll_areset = areset_q;
`else
    assign pll_areset = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_gen.sv
// tb_pll_rst_gen: scoreboard bench with an event-time reference model of the reset sequencer.
module tb_pll_rst_gen;

    localparam int SS   = 2;
    localparam int LSC  = 8;
    localparam int RHC  = 4;
    localparam int CW   = 4;
    localparam int RC   = 32;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic          rst_out_n;
    logic          sys_ready;
    logic          lock_lost;
    logic [CW-1:0] lock_loss_cnt;
    logic [1:0]    state_o;
    logic          pll_areset;

    always #5 clk = ~clk;

    pll_rst_gen #(
        .SYNC_STAGES    (SS),
        .LOCK_STABLE_CYC(LSC),
        .RST_HOLD_CYC   (RHC),
        .CNT_W          (CW),
        .RESTART_CYC    (RC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .rst_out_n    (rst_out_n),
        .sys_ready    (sys_ready),
        .lock_lost    (lock_lost),
        .lock_loss_cnt(lock_loss_cnt),
        .state_o      (state_o),
        .pll_areset   (pll_areset)
    );

    typedef struct {
        int n;
        int st;
        bit rdy;
        bit ll;
        int cnt;
        bit ar;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: the edge at which RUN is due is scheduled when a lock epoch starts
    // (or on a software request), and cancelled by any loss of the synchronized lock.
    int  n, run_at, cnt, to, ar_left, prev_st;
    bit  in_run;
    bit  lq[$];

    always @(posedge clk or negedge rst_n) begin
        bit   l, ll;
        int   st;
        exp_t e;
        if (!rst_n) begin
            n = 0; run_at = -1; in_run = 0; cnt = 0; to = 0; ar_left = 0; prev_st = 0;
            lq.delete();
            sb.delete();
        end else begin
            n++;
            l = (lq.size() == SS) ? lq[0] : 1'b0;
            lq.push_back(pll_locked);
            if (lq.size() > SS) void'(lq.pop_front());
            ll = 1'b0;
            if (!l) begin
                if (in_run) begin
                    ll = 1'b1;
                    if (cnt < CMAX) cnt++;
                end
                in_run = 0;
                run_at = -1;
            end else if (in_run) begin
                if (sw_rst_req) begin
                    in_run = 0;
                    run_at = n + RHC;
                end
            end else if (run_at < 0) begin
                run_at = n + LSC + RHC;
            end else if (n == run_at) begin
                in_run = 1;
            end
            st = in_run ? 3 : (run_at < 0) ? 0 : (n < run_at - RHC) ? 1 : 2;
`ifdef PLL_RESTART_EN
            if (ar_left > 0) ar_left--;
            if (prev_st == 0) begin
                if (to == RC - 1) begin
                    to = 0;
                    ar_left = 8;
                end else to++;
            end else to = 0;
`endif
            prev_st = st;
            e.n = n; e.st = st; e.rdy = in_run; e.ll = ll; e.cnt = cnt; e.ar = (ar_left > 0);
            sb.push_back(e);
        end
    end

    task automatic chk(input string nm, input int edge_n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset state_o", -1, 32'(state_o), 0);
            chk("reset rst_out_n", -1, 32'(rst_out_n), 0);
            chk("reset sys_ready", -1, 32'(sys_ready), 0);
            chk("reset lock_lost", -1, 32'(lock_lost), 0);
            chk("reset lock_loss_cnt", -1, 32'(lock_loss_cnt), 0);
            chk("reset pll_areset", -1, 32'(pll_areset), 0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state_o", e.n, 32'(state_o), 32'(e.st));
            chk("rst_out_n", e.n, 32'(rst_out_n), 32'(e.rdy));
            chk("sys_ready", e.n, 32'(sys_ready), 32'(e.rdy));
            chk("lock_lost", e.n, 32'(lock_lost), 32'(e.ll));
            chk("lock_loss_cnt", e.n, 32'(lock_loss_cnt), 32'(e.cnt));
            chk("pll_areset", e.n, 32'(pll_areset), 32'(e.ar));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic sw_pulse;
        @(negedge clk) sw_rst_req = 1'b1;
        @(negedge clk) sw_rst_req = 1'b0;
    endtask

    initial begin
        cyc(3);
        @(posedge clk) #2 rst_n = 1'b1;
        cyc(4);
        pll_locked = 1'b1;
        cyc(25);
        sw_pulse;
        cyc(10);
        pll_locked = 1'b0;
        cyc(4);
        pll_locked = 1'b1;
        cyc(6);
        pll_locked = 1'b0;
        cyc(3);
        pll_locked = 1'b1;
        cyc(3);
        sw_pulse;
        cyc(25);
        pll_locked = 1'b0;
        cyc(5);
        pll_locked = 1'b1;
        cyc(25);
        pll_locked = 1'b0;
        cyc(1);
        sw_pulse;
        pll_locked = 1'b1;
        cyc(25);
        repeat (17) begin
            pll_locked = 1'b0;
            cyc(3);
            pll_locked = 1'b1;
            cyc(16);
        end
        pll_locked = 1'b0;
        cyc(100);
        pll_locked = 1'b1;
        cyc(25);
        @(posedge clk) #2 rst_n = 1'b0;
        cyc(2);
        @(posedge clk) #2 rst_n = 1'b1;
        cyc(25);
        repeat (80) begin
            int hi;
            hi = $urandom_range(1, 30);
            pll_locked = 1'b1;
            for (int i = 0; i < hi; i++) begin
                sw_rst_req = ($urandom_range(0, 7) == 0);
                cyc(1);
            end
            sw_rst_req = 1'b0;
            pll_locked = 1'b0;
            cyc($urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) cyc(40);
        end
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
